bsg_pipe_mul_fold: RTL and testbench

Parametrised three-stage multiply-and-fold datapath with built-in bubble-collapsing valid/ready control, per-stage register skipping, per-transaction signed/unsigned mode and a pass-through tag. It computes fold(a*b) = high half + low half of the full-width product. It sits between any two ready/valid (ready_and) endpoints as a drop-in arithmetic pipe. It supersedes hand-built controller-plus-segmented-register pairings for this function.

---
 rtl/bsg_pipe_mul_fold.sv | 199 +++++++++++++++++++
 tb/tb_bsg_pipe_mul_fold.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_pipe_mul_fold.sv
// bsg_pipe_mul_fold: three-stage pipe computing fold(a*b) = hi(a*b) + lo(a*b) mod 2^width_p.
// Latency: one cycle per registered stage (number of zero bits in skip_p); throughput 1/cycle.
// Backpressure: bubble-collapsing ready/valid; an empty stage always loads; ready_and_o may depend on ready_and_i.
//
// Ports:
//   clk_i, reset_i        clock and synchronous active-high reset
//   v_i / ready_and_o     input handshake, operands a_i, b_i, mode signed_i, opaque tag_i
//   v_o / ready_and_i     output handshake, result data_o with its tag_o
//   count_o               number of valid entries held in registered stages
module bsg_pipe_mul_fold #(
  parameter int         width_p     = 32,
  parameter int         tag_width_p = 4,
  parameter logic [2:0] skip_p      = 3'b000
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   v_i,
  output logic                   ready_and_o,
  input  logic [width_p-1:0]     a_i,
  input  logic [width_p-1:0]     b_i,
  input  logic                   signed_i,
  input  logic [tag_width_p-1:0] tag_i,
  output logic                   v_o,
  input  logic                   ready_and_i,
  output logic [width_p-1:0]     data_o,
  output logic [tag_width_p-1:0] tag_o,
  output logic [1:0]             count_o
);

  localparam int W = width_p;
  localparam int T = tag_width_p;

  // Outputs of each stage (registered or pass-through).
  logic           s1_v;
  logic [W-1:0]   s1_a;
  logic [W-1:0]   s1_b;
  logic           s1_sgn;
  logic [T-1:0]   s1_tag;
  logic           s2_v;
  logic [2*W-1:0] s2_p;
  logic [T-1:0]   s2_tag;
  logic           s3_v;
  logic [W-1:0]   s3_d;
  logic [T-1:0]   s3_tag;

  // Valid bits of registered stages; a skipped stage holds nothing and reads as 0.
  logic [2:0] vq;

  // Advance conditions, resolved back to front. A skipped stage simply
  // inherits the advance of whatever follows it.
  logic s1_adv, s2_adv, s3_adv;
  assign s3_adv = skip_p[2] ? ready_and_i : (~vq[2] | ready_and_i);
  assign s2_adv = skip_p[1] ? s3_adv      : (~vq[1] | s3_adv);
  assign s1_adv = skip_p[0] ? s2_adv      : (~vq[0] | s2_adv);

  // Multiply at full 2W width: extending both operands to 2W bits and keeping
  // the low 2W bits of the product gives the exact signed or unsigned result.
  logic [2*W-1:0] mul_a, mul_b, mul_p;
  assign mul_a = {{W{s1_sgn & s1_a[W-1]}}, s1_a};
  assign mul_b = {{W{s1_sgn & s1_b[W-1]}}, s1_b};
  assign mul_p = mul_a * mul_b;

  // Fold: carry out of the W-bit add is intentionally dropped.
  logic [W-1:0] fold_d;
  assign fold_d = s2_p[2*W-1:W] + s2_p[W-1:0];

  // ---------------- S1: operand capture ----------------
  if (skip_p[0]) begin : g_s1_comb
    assign s1_v   = v_i;
    assign s1_a   = a_i;
    assign s1_b   = b_i;
    assign s1_sgn = signed_i;
    assign s1_tag = tag_i;
    assign vq[0]  = 1'b0;
  end else begin : g_s1_reg
    logic         v_q, v_d, sgn_q, sgn_d;
    logic [W-1:0] a_q, a_d, b_q, b_d;
    logic [T-1:0] tag_q, tag_d;

    always_comb begin
      v_d   = v_q;
      a_d   = a_q;
      b_d   = b_q;
      sgn_d = sgn_q;
      tag_d = tag_q;
      if (s1_adv) begin
        v_d   = v_i;
        a_d   = a_i;
        b_d   = b_i;
        sgn_d = signed_i;
        tag_d = tag_i;
      end
    end

    always_ff @(posedge clk_i) begin
      if (reset_i) v_q <= 1'b0;
      else         v_q <= v_d;
    end

    // Data registers carry no reset; the valid bit qualifies them.
    always_ff @(posedge clk_i) begin
      a_q   <= a_d;
      b_q   <= b_d;
      sgn_q <= sgn_d;
      tag_q <= tag_d;
    end

    assign s1_v   = v_q;
    assign s1_a   = a_q;
    assign s1_b   = b_q;
    assign s1_sgn = sgn_q;
    assign s1_tag = tag_q;
    assign vq[0]  = v_q;
  end

  // ---------------- S2: product ----------------
  if (skip_p[1]) begin : g_s2_comb
    assign s2_v   = s1_v;
    assign s2_p   = mul_p;
    assign s2_tag = s1_tag;
    assign vq[1]  = 1'b0;
  end else begin : g_s2_reg
    logic           v_q, v_d;
    logic [2*W-1:0] p_q, p_d;
    logic [T-1:0]   tag_q, tag_d;

    always_comb begin
      v_d   = v_q;
      p_d   = p_q;
      tag_d = tag_q;
      if (s2_adv) begin
        v_d   = s1_v;
        p_d   = mul_p;
        tag_d = s1_tag;
      end
    end

    always_ff @(posedge clk_i) begin
      if (reset_i) v_q <= 1'b0;
      else         v_q <= v_d;
    end

    always_ff @(posedge clk_i) begin
      p_q   <= p_d;
      tag_q <= tag_d;
    end

    assign s2_v   = v_q;
    assign s2_p   = p_q;
    assign s2_tag = tag_q;
    assign vq[1]  = v_q;
  end

  // ---------------- S3: fold ----------------
  if (skip_p[2]) begin : g_s3_comb
    assign s3_v   = s2_v;
    assign s3_d   = fold_d;
    assign s3_tag = s2_tag;
    assign vq[2]  = 1'b0;
  end else begin : g_s3_reg
    logic         v_q, v_d;
    logic [W-1:0] d_q, d_d;
    logic [T-1:0] tag_q, tag_d;

    always_comb begin
      v_d   = v_q;
      d_d   = d_q;
      tag_d = tag_q;
      if (s3_adv) begin
        v_d   = s2_v;
        d_d   = fold_d;
        tag_d = s2_tag;
      end
    end

    always_ff @(posedge clk_i) begin
      if (reset_i) v_q <= 1'b0;
      else         v_q <= v_d;
    end

    always_ff @(posedge clk_i) begin
      d_q   <= d_d;
      tag_q <= tag_d;
    end

    assign s3_v   = v_q;
    assign s3_d   = d_q;
    assign s3_tag = tag_q;
    assign vq[2]  = v_q;
  end

  // Nothing is accepted while reset is held.
  assign ready_and_o = s1_adv & ~reset_i;
  assign v_o         = s3_v;
  assign data_o      = s3_d;
  assign tag_o       = s3_tag;
  assign count_o     = 2'(vq[0]) + 2'(vq[1]) + 2'(vq[2]);

endmodule

// File: tb/tb_bsg_pipe_mul_fold.sv
`timescale 1ns/1ps
module tb_bsg_pipe_mul_fold;

  localparam int W = 32;
  localparam int T = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic [W-1:0] a, b;
  logic         sgn;
  logic [T-1:0] tag;

  // main instance, skip_p = 000
  logic         m_v_i, m_rdy_o, m_v_o, m_rdy_i;
  logic [W-1:0] m_data;
  logic [T-1:0] m_tag;
  logic [1:0]   m_cnt;
  // skip_p = 010
  logic         k_v_i, k_rdy_o, k_v_o, k_rdy_i;
  logic [W-1:0] k_data;
  logic [T-1:0] k_tag;
  logic [1:0]   k_cnt;
  // skip_p = 111
  logic         c_v_i, c_rdy_o, c_v_o, c_rdy_i;
  logic [W-1:0] c_data;
  logic [T-1:0] c_tag;
  logic [1:0]   c_cnt;

  int n_vec = 0;
  int n_err = 0;

  bsg_pipe_mul_fold #(.width_p(W), .tag_width_p(T), .skip_p(3'b000)) u_dut (
    .clk_i(clk), .reset_i(reset), .v_i(m_v_i), .ready_and_o(m_rdy_o),
    .a_i(a), .b_i(b), .signed_i(sgn), .tag_i(tag),
    .v_o(m_v_o), .ready_and_i(m_rdy_i), .data_o(m_data), .tag_o(m_tag), .count_o(m_cnt));

  bsg_pipe_mul_fold #(.width_p(W), .tag_width_p(T), .skip_p(3'b010)) u_dut_k (
    .clk_i(clk), .reset_i(reset), .v_i(k_v_i), .ready_and_o(k_rdy_o),
    .a_i(a), .b_i(b), .signed_i(sgn), .tag_i(tag),
    .v_o(k_v_o), .ready_and_i(k_rdy_i), .data_o(k_data), .tag_o(k_tag), .count_o(k_cnt));

  bsg_pipe_mul_fold #(.width_p(W), .tag_width_p(T), .skip_p(3'b111)) u_dut_c (
    .clk_i(clk), .reset_i(reset), .v_i(c_v_i), .ready_and_o(c_rdy_o),
    .a_i(a), .b_i(b), .signed_i(sgn), .tag_i(tag),
    .v_o(c_v_o), .ready_and_i(c_rdy_i), .data_o(c_data), .tag_o(c_tag), .count_o(c_cnt));

  // Reference: exact 64-bit product via integer arithmetic, then fold.
  function automatic logic [31:0] fold_ref(input logic [31:0] x, input logic [31:0] y, input logic s);
    longint px, py;
    logic [63:0] p;
    px = s ? longint'(int'(x)) : longint'({32'b0, x});
    py = s ? longint'(int'(y)) : longint'({32'b0, y});
    p  = px * py;
    return p[63:32] + p[31:0];
  endfunction

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  t;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  logic hold_q = 1'b0;
  logic [W-1:0] hold_d;
  logic [T-1:0] hold_t;

  // Scoreboard for the main instance: push on input handshake, pop and compare
  // on output handshake; also check that a stalled output stays stable.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      sbq.delete();
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        n_vec++;
        if (m_v_o !== 1'b1 || m_data !== hold_d || m_tag !== hold_t) begin
          n_err++;
          $display("FAIL hold_stable: got v=%b data=%h tag=%h, required v=1 data=%h tag=%h",
                   m_v_o, m_data, m_tag, hold_d, hold_t);
        end
      end
      if (m_v_i === 1'b1 && m_rdy_o === 1'b1) begin
        mon_e.d = fold_ref(a, b, sgn);
        mon_e.t = tag;
        sbq.push_back(mon_e);
      end
      if (m_v_o === 1'b1 && m_rdy_i === 1'b1) begin
        n_vec++;
        if (sbq.size() == 0) begin
          n_err++;
          $display("FAIL sb_unexpected: got output data=%h tag=%h, required no output", m_data, m_tag);
        end else begin
          mon_e = sbq.pop_front();
          if (m_data !== mon_e.d || m_tag !== mon_e.t) begin
            n_err++;
            $display("FAIL sb_data: got data=%h tag=%h, required data=%h tag=%h",
                     m_data, m_tag, mon_e.d, mon_e.t);
          end
        end
      end
      hold_q = (m_v_o === 1'b1) && (m_rdy_i !== 1'b1);
      hold_d = m_data;
      hold_t = m_tag;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) tick;
    @(negedge clk);
    n_vec++;
    if (m_rdy_o !== 1'b0) begin n_err++; $display("FAIL reset_rdy_low: got %b, required 0", m_rdy_o); end
    tick;
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (m_v_o !== 1'b0) begin n_err++; $display("FAIL reset_v_o: got %b, required 0", m_v_o); end
    n_vec++;
    if (m_cnt !== 2'd0) begin n_err++; $display("FAIL reset_count: got %0d, required 0", m_cnt); end
    n_vec++;
    if (m_rdy_o !== 1'b1) begin n_err++; $display("FAIL reset_rdy: got %b, required 1", m_rdy_o); end
    tick;
  endtask

  task automatic test_single;
    m_rdy_i = 1'b1;
    a = 32'd3; b = 32'd5; sgn = 1'b0; tag = 4'd1; m_v_i = 1'b1;
    @(negedge clk);
    n_vec++;
    if (m_rdy_o !== 1'b1) begin n_err++; $display("FAIL single_accept: got %b, required 1", m_rdy_o); end
    tick;
    m_v_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (m_v_o !== 1'b0 || m_cnt !== 2'd1) begin
      n_err++; $display("FAIL single_lat1: got v=%b cnt=%0d, required v=0 cnt=1", m_v_o, m_cnt);
    end
    tick;
    @(negedge clk);
    n_vec++;
    if (m_v_o !== 1'b0) begin n_err++; $display("FAIL single_lat2: got v=%b, required 0", m_v_o); end
    tick;
    @(negedge clk);
    n_vec++;
    if (m_v_o !== 1'b1 || m_data !== 32'd15 || m_tag !== 4'd1) begin
      n_err++; $display("FAIL single_out: got v=%b data=%h tag=%h, required v=1 data=0000000f tag=1", m_v_o, m_data, m_tag);
    end
    tick;
    @(negedge clk);
    n_vec++;
    if (m_cnt !== 2'd0 || m_v_o !== 1'b0) begin
      n_err++; $display("FAIL single_empty: got cnt=%0d v=%b, required cnt=0 v=0", m_cnt, m_v_o);
    end
    tick;
  endtask

  task automatic test_fold_sign;
    logic [31:0] ta [3];
    logic [31:0] tb [3];
    logic        ts [3];
    logic [31:0] te [3];
    logic        seen;
    ta[0] = 32'h0001_0000; tb[0] = 32'h0001_0000; ts[0] = 1'b0; te[0] = 32'h0000_0001;
    ta[1] = 32'hFFFF_FFFF; tb[1] = 32'd2;         ts[1] = 1'b0; te[1] = 32'hFFFF_FFFF;
    ta[2] = 32'hFFFF_FFFF; tb[2] = 32'd2;         ts[2] = 1'b1; te[2] = 32'hFFFF_FFFD;
    m_rdy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = ta[i]; b = tb[i]; sgn = ts[i]; tag = 4'(i + 2); m_v_i = 1'b1;
      tick;
      m_v_i = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
        @(negedge clk);
        if (m_v_o === 1'b1) seen = 1'b1;
        else tick;
      end
      n_vec++;
      if (!seen) begin
        n_err++; $display("FAIL fold_timeout[%0d]: got no v_o within 8 cycles, required output", i);
      end else if (m_data !== te[i]) begin
        n_err++; $display("FAIL fold_value[%0d]: got %h, required %h", i, m_data, te[i]);
      end
      tick;
    end
  endtask

  task automatic test_bubble;
    m_rdy_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 32'(i + 10); b = 32'(i + 20); sgn = 1'b0; tag = 4'(i + 1); m_v_i = 1'b1;
      @(negedge clk);
      n_vec++;
      if (m_rdy_o !== 1'b1) begin n_err++; $display("FAIL bubble_accept[%0d]: got %b, required 1", i, m_rdy_o); end
      tick;
      m_v_i = 1'b0;
      tick;
    end
    @(negedge clk);
    n_vec++;
    if (m_cnt !== 2'd3) begin n_err++; $display("FAIL bubble_count: got %0d, required 3", m_cnt); end
    n_vec++;
    if (m_rdy_o !== 1'b0) begin n_err++; $display("FAIL bubble_full_rdy: got %b, required 0", m_rdy_o); end
    repeat (3) tick;
    m_rdy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (m_v_o !== 1'b1 || m_tag !== 4'(i + 1)) begin
        n_err++; $display("FAIL bubble_drain[%0d]: got v=%b tag=%0d, required v=1 tag=%0d", i, m_v_o, m_tag, i + 1);
      end
      tick;
    end
    @(negedge clk);
    n_vec++;
    if (m_cnt !== 2'd0) begin n_err++; $display("FAIL bubble_empty: got %0d, required 0", m_cnt); end
    tick;
  endtask

  task automatic test_stream;
    int acc, cyc;
    acc = 0; cyc = 0;
    while (acc < 1000 && cyc < 20000) begin
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      sgn = 1'($urandom_range(0, 1));
      tag = 4'($urandom_range(0, 15));
      m_v_i   = ($urandom_range(0, 3) != 0);
      m_rdy_i = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (m_v_i === 1'b1 && m_rdy_o === 1'b1) acc++;
      tick;
      cyc++;
    end
    m_v_i = 1'b0;
    m_rdy_i = 1'b1;
    cyc = 0;
    while (sbq.size() != 0 && cyc < 50) begin
      tick;
      cyc++;
    end
    tick;
    n_vec++;
    if (acc < 1000) begin n_err++; $display("FAIL stream_accepts: got %0d, required 1000", acc); end
    n_vec++;
    if (sbq.size() != 0) begin n_err++; $display("FAIL stream_drain: got %0d pending, required 0", sbq.size()); end
    n_vec++;
    if (m_cnt !== 2'd0) begin n_err++; $display("FAIL stream_count: got %0d, required 0", m_cnt); end
  endtask

  task automatic test_skip;
    logic [2:0] acc;
    // skip_p = 010: two registered stages
    k_rdy_i = 1'b1;
    a = 32'd7; b = 32'd9; sgn = 1'b0; tag = 4'd5; k_v_i = 1'b1;
    @(negedge clk);
    n_vec++;
    if (k_rdy_o !== 1'b1) begin n_err++; $display("FAIL skip2_accept: got %b, required 1", k_rdy_o); end
    tick;
    k_v_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (k_v_o !== 1'b0) begin n_err++; $display("FAIL skip2_lat1: got %b, required 0", k_v_o); end
    tick;
    @(negedge clk);
    n_vec++;
    if (k_v_o !== 1'b1 || k_data !== 32'd63 || k_tag !== 4'd5) begin
      n_err++; $display("FAIL skip2_out: got v=%b data=%h tag=%h, required v=1 data=0000003f tag=5", k_v_o, k_data, k_tag);
    end
    tick;
    k_rdy_i = 1'b0;
    acc = 3'b000;
    for (int i = 0; i < 3; i++) begin
      a = 32'(i + 1); b = 32'd3; tag = 4'(i); k_v_i = 1'b1;
      @(negedge clk);
      acc[i] = (k_rdy_o === 1'b1);
      tick;
    end
    k_v_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (acc !== 3'b011) begin n_err++; $display("FAIL skip2_fill: got accepts=%b, required 011", acc); end
    n_vec++;
    if (k_cnt !== 2'd2 || k_rdy_o !== 1'b0) begin
      n_err++; $display("FAIL skip2_full: got cnt=%0d rdy=%b, required cnt=2 rdy=0", k_cnt, k_rdy_o);
    end
    tick;
    k_rdy_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_vec++;
      if (k_v_o !== 1'b1 || k_data !== 32'(3 * (i + 1)) || k_tag !== 4'(i)) begin
        n_err++; $display("FAIL skip2_drain[%0d]: got v=%b data=%h tag=%0d, required v=1 data=%h tag=%0d",
                          i, k_v_o, k_data, k_tag, 32'(3 * (i + 1)), i);
      end
      tick;
    end
    @(negedge clk);
    n_vec++;
    if (k_cnt !== 2'd0 || k_v_o !== 1'b0) begin
      n_err++; $display("FAIL skip2_empty: got cnt=%0d v=%b, required cnt=0 v=0", k_cnt, k_v_o);
    end
    tick;

    // skip_p = 111: purely combinational
    a = 32'hFFFF_FFFF; b = 32'd2; sgn = 1'b1; tag = 4'd9; c_v_i = 1'b1; c_rdy_i = 1'b0;
    #1;
    n_vec++;
    if (c_v_o !== 1'b1 || c_data !== 32'hFFFF_FFFD || c_tag !== 4'd9) begin
      n_err++; $display("FAIL comb_out: got v=%b data=%h tag=%h, required v=1 data=fffffffd tag=9", c_v_o, c_data, c_tag);
    end
    n_vec++;
    if (c_rdy_o !== 1'b0 || c_cnt !== 2'd0) begin
      n_err++; $display("FAIL comb_rdy_low: got rdy=%b cnt=%0d, required rdy=0 cnt=0", c_rdy_o, c_cnt);
    end
    c_rdy_i = 1'b1;
    #1;
    n_vec++;
    if (c_rdy_o !== 1'b1) begin n_err++; $display("FAIL comb_rdy_high: got %b, required 1", c_rdy_o); end
    c_v_i = 1'b0;
    #1;
    n_vec++;
    if (c_v_o !== 1'b0) begin n_err++; $display("FAIL comb_v_low: got %b, required 0", c_v_o); end
    tick;
  endtask

  task automatic test_reset_mid;
    logic seen;
    m_rdy_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = 32'(i + 100); b = 32'd3; sgn = 1'b0; tag = 4'(i + 1); m_v_i = 1'b1;
      tick;
    end
    m_v_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (m_cnt !== 2'd3) begin n_err++; $display("FAIL mid_fill: got %0d, required 3", m_cnt); end
    tick;
    reset = 1'b1;
    m_rdy_i = 1'b1;
    tick;
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (m_v_o !== 1'b0 || m_cnt !== 2'd0 || m_rdy_o !== 1'b1) begin
      n_err++; $display("FAIL mid_reset: got v=%b cnt=%0d rdy=%b, required v=0 cnt=0 rdy=1", m_v_o, m_cnt, m_rdy_o);
    end
    for (int i = 0; i < 6; i++) begin
      tick;
      @(negedge clk);
      n_vec++;
      if (m_v_o !== 1'b0) begin n_err++; $display("FAIL mid_stale[%0d]: got v=%b, required 0", i, m_v_o); end
    end
    tick;
    a = 32'd6; b = 32'd7; sgn = 1'b1; tag = 4'd4; m_v_i = 1'b1;
    tick;
    m_v_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (m_v_o === 1'b1) seen = 1'b1;
      else tick;
    end
    n_vec++;
    if (!seen || m_data !== 32'd42 || m_tag !== 4'd4) begin
      n_err++; $display("FAIL mid_after: got seen=%b data=%h tag=%0d, required seen=1 data=0000002a tag=4", seen, m_data, m_tag);
    end
    tick;
  endtask

  initial begin
    reset = 1'b1;
    a = '0; b = '0; sgn = 1'b0; tag = '0;
    m_v_i = 1'b0; m_rdy_i = 1'b1;
    k_v_i = 1'b0; k_rdy_i = 1'b1;
    c_v_i = 1'b0; c_rdy_i = 1'b1;
    test_reset;
    test_single;
    test_fold_sign;
    test_bubble;
    test_stream;
    test_skip;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

endmodule
